// File: rtl/parallel_to_serial_framed.sv
// Framed parallel-to-serial output serializer.
// Streams WIDTH-bit words over LANES pads with frame and first-beat strobes.
module parallel_to_serial_framed #(
  parameter int WIDTH     = 128,
  parameter int LANES     = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LANES-1:0] data_out,
  output logic             frame_out,
  output logic             first_out,
  output logic             busy
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [LANES-1:0] dout_q, dout_d;
  logic             frame_q, frame_d;
  logic             first_q, first_d;
  logic             accept;
  logic [LANES-1:0] in_lead, sr_lead;
  logic [WIDTH-1:0] in_rest, sr_rest;

  // sreg holds the beats still to come; the head chunk is always next
  always_comb begin
    if (LSB_FIRST) begin
      in_lead = data_in[LANES-1:0];
      sr_lead = sreg_q[LANES-1:0];
      in_rest = data_in >> LANES;
      sr_rest = sreg_q >> LANES;
    end else begin
      in_lead = data_in[WIDTH-1 -: LANES];
      sr_lead = sreg_q[WIDTH-1 -: LANES];
      in_rest = data_in << LANES;
      sr_rest = sreg_q << LANES;
    end
  end

  assign in_ready = !RST &&
                    ((state_q == IDLE) || (cnt_q == LAST));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    dout_d  = dout_q;
    frame_d = frame_q;
    first_d = first_q;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sreg_d  = in_rest;
      dout_d  = in_lead;
      frame_d = 1'b1;
      first_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          dout_d  = '0;
          frame_d = 1'b0;
          first_d = 1'b0;
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            sreg_d  = '0;
            dout_d  = '0;
            frame_d = 1'b0;
            first_d = 1'b0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            sreg_d  = sr_rest;
            dout_d  = sr_lead;
            first_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      dout_q  <= '0;
      frame_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      dout_q  <= dout_d;
      frame_q <= frame_d;
      first_q <= first_d;
    end
  end

  assign data_out  = dout_q;
  assign frame_out = frame_q;
  assign first_out = first_q;
  assign busy      = (state_q == SHIFT);

endmodule
